descriptor_dispatch: RTL and testbench
======================================

# descriptor_dispatch

Downstream consumer of the host/network descriptor arbiter's input-queue FIFO. Each entry is one 57-bit descriptor `{tsntag[47:0], bufid[8:0]}`. The block pops one descriptor at a time and looks up the flow's output-port bitmap in the forwarding RAM. It then writes the bufid into every selected output-port queue, or returns the buffer to the free pool when the bitmap is empty. It also reports a reference count to the buffer manager so the buffer is freed after the last port transmits.

## Interface
Parameters:
- PORT_NUM, 8, number of output ports; width of bitmap, queue-write and queue-full vectors
- FLOWID_W, 14, forwarding-RAM address width; flowid = tsntag[44:31]

Ports (clock i_clk; reset i_rst_n, asynchronous, active-low):
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- iv_fifo_rdata  in  57  FIFO head; valid the cycle after o_fifo_rd is high
- i_fifo_empty  in  1  FIFO empty
- o_fifo_rd  out  1  one-cycle pop pulse
- ov_ram_addr  out  FLOWID_W  forwarding-RAM address (flowid)
- o_ram_rd  out  1  RAM read strobe
- iv_ram_rdata  in  PORT_NUM  port bitmap; valid 2 cycles after o_ram_rd is high
- i_queue_full  in  PORT_NUM  per-port output-queue full
- ov_queue_wdata  out  9  bufid, broadcast to all ports
- ov_queue_wr  out  PORT_NUM  per-port write pulse
- ov_refcnt  out  4  number of ports written (popcount)
- o_refcnt_wr  out  1  refcount write pulse, coincident with ov_queue_wr
- ov_free_bufid  out  9  bufid to free (empty bitmap)
- o_free_wr  out  1  free request; held until ack
- i_free_ack  in  1  free accepted

## Operation
- All outputs are registered and all reset to 0. The FSM resets to IDLE_S.
- IDLE_S:
  - If i_fifo_empty=0, set o_fifo_rd=1 and go to RD_S.
  - Otherwise stay.
- RD_S:
  - Drop o_fifo_rd.
  - Go to LATCH_S.
- LATCH_S:
  - Latch iv_fifo_rdata: bufid=[8:0], flowid=[44+9:31+9], i.e. tsntag[44:31].
  - Drive ov_ram_addr=flowid and o_ram_rd=1.
  - Go to WAIT1_S.
- WAIT1_S:
  - Drop o_ram_rd.
  - Go to WAIT2_S.
- WAIT2_S:
  - Latch iv_ram_rdata into the bitmap register.
  - Go to CHECK_S.
- CHECK_S:
  - If bitmap==0: drive ov_free_bufid=bufid and o_free_wr=1, then go to FREE_S.
  - Else if (bitmap & i_queue_full)!=0: stay in CHECK_S. This is all-or-nothing; no partial writes.
  - Else: drive ov_queue_wr=bitmap, ov_queue_wdata=bufid, ov_refcnt=popcount(bitmap) and o_refcnt_wr=1 for one cycle, then go to IDLE_S.
- FREE_S:
  - Hold o_free_wr and ov_free_bufid until i_free_ack=1.
  - On the ack cycle, clear both and go to IDLE_S.
- Any undefined state goes to IDLE_S with all strobes 0.
- ov_queue_wdata, ov_refcnt and ov_free_bufid return to 0 when their strobe is low.

## Timing
- Cycle 0: IDLE_S samples i_fifo_empty=0.
- Cycle 1: o_fifo_rd=1.
- Cycle 2: data is latched.
- Cycle 3: o_ram_rd=1.
- Cycle 5: bitmap is latched.
- Cycle 6: CHECK_S.
- Cycle 7: ov_queue_wr and o_refcnt_wr are high.
- The earliest next o_fifo_rd is cycle 8, giving 7 cycles per descriptor when no queue is full.
- Each cycle of selected-port full adds one cycle of latency. Unselected full ports never stall.
- Only one descriptor is in flight. The FIFO is never popped while the block is in any state other than IDLE_S.
- Free ack in the same cycle o_free_wr first rises is not possible, because the request is registered. The earliest ack is cycle 7, returning to IDLE in cycle 8.
- popcount max is PORT_NUM. 4 bits covers PORT_NUM ≤ 15.
- Reset mid-operation clears the FSM and outputs immediately. The in-flight descriptor is lost, which is accepted and relies on the system-level buffer reinit.

## Structure
- Shared package tse_pkg holds:
  - DESC_W=57, BUFID_W=9, TSNTAG_W=48
  - flowid bit positions
  - state encodings (localparam 4-bit)
- popcount is a function in tse_pkg, not a sub-module.
- No sub-module. A single FSM of about 200 lines.

## Test plan
- Single descriptor {tsntag flowid=14'd5, bufid=9'd17} with RAM[5]=8'b0000_0101:
  - o_fifo_rd in cycle 1.
  - Cycle 7: ov_queue_wr=8'h05, ov_queue_wdata=17, ov_refcnt=2, o_refcnt_wr=1, each for 1 cycle.
- RAM[9]=0 with bufid 33: o_free_wr=1 with ov_free_bufid=33, held for 3 cycles until i_free_ack. No queue write and no refcnt.
- Bitmap 8'h81 with i_queue_full[7]=1 for 4 cycles:
  - CHECK_S holds.
  - Write lands in the cycle after full drops, with ov_queue_wr=8'h81.
  - i_queue_full[3] toggling has no effect.
- Three back-to-back FIFO entries: o_fifo_rd pulses exactly 3 times, 7 cycles apart. The outputs carry bufids in FIFO order.
- Assert i_rst_n low during WAIT1_S:
  - All outputs are 0 immediately.
  - After release, the next non-empty FIFO entry is processed normally from IDLE_S.
- i_fifo_empty=1 for the whole run: no strobe is ever asserted.

Source files
------------

// File: rtl/tse_pkg.sv
// Shared TSN switch-element definitions: descriptor layout, dispatcher
// state codes and the popcount helper used for buffer reference counts.
package tse_pkg;

  localparam int BUFID_W  = 9;
  localparam int TSNTAG_W = 48;
  localparam int DESC_W   = TSNTAG_W + BUFID_W;

  // flowid sits at tsntag[44:31]; in the packed descriptor that is shifted by the bufid
  localparam int FLOWID_TAG_LSB = 31;
  localparam int FLOWID_LSB     = BUFID_W + FLOWID_TAG_LSB;

  localparam int REFCNT_W    = 4;
  localparam int POPCNT_IN_W = 15;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_RD    = 4'd1;
  localparam logic [3:0] ST_LATCH = 4'd2;
  localparam logic [3:0] ST_WAIT1 = 4'd3;
  localparam logic [3:0] ST_WAIT2 = 4'd4;
  localparam logic [3:0] ST_CHECK = 4'd5;
  localparam logic [3:0] ST_FREE  = 4'd6;

  typedef enum logic [3:0] {
    IDLE_S  = ST_IDLE,
    RD_S    = ST_RD,
    LATCH_S = ST_LATCH,
    WAIT1_S = ST_WAIT1,
    WAIT2_S = ST_WAIT2,
    CHECK_S = ST_CHECK,
    FREE_S  = ST_FREE
  } dispatch_state_t;

  // 4-bit result is exact for up to 15 ports
  function automatic logic [REFCNT_W-1:0] popcount(input logic [POPCNT_IN_W-1:0] v);
    logic [REFCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POPCNT_IN_W; i++) begin
      cnt = cnt + REFCNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/descriptor_dispatch_if.sv
// Bundle of the dispatcher's FIFO, forwarding-RAM, output-queue and
// buffer-free connections; master is the dispatcher side.
interface descriptor_dispatch_if import tse_pkg::*; #(
  parameter int PORT_NUM = 8,
  parameter int FLOWID_W = 14
);

  logic [DESC_W-1:0]   iv_fifo_rdata;
  logic                i_fifo_empty;
  logic                o_fifo_rd;

  logic [FLOWID_W-1:0] ov_ram_addr;
  logic                o_ram_rd;
  logic [PORT_NUM-1:0] iv_ram_rdata;

  logic [PORT_NUM-1:0] i_queue_full;
  logic [BUFID_W-1:0]  ov_queue_wdata;
  logic [PORT_NUM-1:0] ov_queue_wr;
  logic [REFCNT_W-1:0] ov_refcnt;
  logic                o_refcnt_wr;

  logic [BUFID_W-1:0]  ov_free_bufid;
  logic                o_free_wr;
  logic                i_free_ack;

  modport master (
    input  iv_fifo_rdata, i_fifo_empty, iv_ram_rdata, i_queue_full, i_free_ack,
    output o_fifo_rd, ov_ram_addr, o_ram_rd, ov_queue_wdata, ov_queue_wr,
           ov_refcnt, o_refcnt_wr, ov_free_bufid, o_free_wr
  );

  modport slave (
    output iv_fifo_rdata, i_fifo_empty, iv_ram_rdata, i_queue_full, i_free_ack,
    input  o_fifo_rd, ov_ram_addr, o_ram_rd, ov_queue_wdata, ov_queue_wr,
           ov_refcnt, o_refcnt_wr, ov_free_bufid, o_free_wr
  );

endinterface

// File: rtl/descriptor_dispatch.sv
// Pops one descriptor at a time, looks up its port bitmap and either
// enqueues the bufid on every selected port or hands the buffer back.
module descriptor_dispatch import tse_pkg::*; #(
  parameter int PORT_NUM = 8,
  parameter int FLOWID_W = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  descriptor_dispatch_if.master bus
);

  dispatch_state_t     state;
  logic [BUFID_W-1:0]  bufid;
  logic [PORT_NUM-1:0] bitmap;
  logic                ram_wait_done;

  // One descriptor in flight; every output is a register so downstream sees clean strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= IDLE_S;
      bufid              <= '0;
      bitmap             <= '0;
      ram_wait_done      <= 1'b0;
      bus.o_fifo_rd      <= 1'b0;
      bus.ov_ram_addr    <= '0;
      bus.o_ram_rd       <= 1'b0;
      bus.ov_queue_wdata <= '0;
      bus.ov_queue_wr    <= '0;
      bus.ov_refcnt      <= '0;
      bus.o_refcnt_wr    <= 1'b0;
      bus.ov_free_bufid  <= '0;
      bus.o_free_wr      <= 1'b0;
    end else begin
      bus.o_fifo_rd      <= 1'b0;
      bus.o_ram_rd       <= 1'b0;
      bus.ov_queue_wdata <= '0;
      bus.ov_queue_wr    <= '0;
      bus.ov_refcnt      <= '0;
      bus.o_refcnt_wr    <= 1'b0;

      case (state)
        IDLE_S: begin
          if (!bus.i_fifo_empty) begin
            bus.o_fifo_rd <= 1'b1;
            state         <= RD_S;
          end
        end

        RD_S: begin
          state <= LATCH_S;
        end

        LATCH_S: begin
          bufid           <= bus.iv_fifo_rdata[BUFID_W-1:0];
          bus.ov_ram_addr <= bus.iv_fifo_rdata[FLOWID_LSB +: FLOWID_W];
          bus.o_ram_rd    <= 1'b1;
          ram_wait_done   <= 1'b0;
          state           <= WAIT1_S;
        end

        // The RAM answers two cycles after it sees our registered strobe, so wait here twice.
        WAIT1_S: begin
          if (!ram_wait_done) begin
            ram_wait_done <= 1'b1;
          end else begin
            state <= WAIT2_S;
          end
        end

        WAIT2_S: begin
          bitmap <= bus.iv_ram_rdata;
          state  <= CHECK_S;
        end

        // All-or-nothing: any selected port full stalls the whole descriptor.
        CHECK_S: begin
          if (bitmap == '0) begin
            bus.ov_free_bufid <= bufid;
            bus.o_free_wr     <= 1'b1;
            state             <= FREE_S;
          end else if ((bitmap & bus.i_queue_full) == '0) begin
            bus.ov_queue_wr    <= bitmap;
            bus.ov_queue_wdata <= bufid;
            bus.ov_refcnt      <= popcount(POPCNT_IN_W'(bitmap));
            bus.o_refcnt_wr    <= 1'b1;
            state              <= IDLE_S;
          end
        end

        FREE_S: begin
          if (bus.i_free_ack) begin
            bus.o_free_wr     <= 1'b0;
            bus.ov_free_bufid <= '0;
            state             <= IDLE_S;
          end
        end

        default: begin
          bus.o_free_wr     <= 1'b0;
          bus.ov_free_bufid <= '0;
          state             <= IDLE_S;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_descriptor_dispatch.sv
// Scoreboard bench for descriptor_dispatch: FIFO/RAM/queue/free models drive the
// DUT, expectations are queued at push time and a monitor compares every strobe.
module tb_descriptor_dispatch;
  import tse_pkg::*;

  localparam int PORT_NUM  = 8;
  localparam int FLOWID_W  = 14;
  localparam int NUM_FLOWS = 1 << FLOWID_W;

  typedef struct {
    bit                  is_free;
    logic [BUFID_W-1:0]  bufid;
    logic [PORT_NUM-1:0] bitmap;
    int                  refcnt;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  descriptor_dispatch_if #(.PORT_NUM(PORT_NUM), .FLOWID_W(FLOWID_W)) bus ();

  descriptor_dispatch #(.PORT_NUM(PORT_NUM), .FLOWID_W(FLOWID_W)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [PORT_NUM-1:0] fwd_ram [NUM_FLOWS];
  logic [DESC_W-1:0]   fifo_q[$];
  exp_t                sb[$];
  int                  rd_cycles[$];

  int                  ack_delay   = 1;
  bit                  stall_arm   = 1'b0;
  logic [PORT_NUM-1:0] full_mask   = '0;
  bit                  full_sparse = 1'b0;

  bit in_flight   = 1'b0;
  bit free_active = 1'b0;
  int mon_rd_cyc  = 0;
  int exp_done    = -1;
  int free_len    = 0;
  int last_lat    = 0;
  int strobe_seen = 0;
  logic [BUFID_W-1:0] free_bufid_exp;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({bus.o_fifo_rd, bus.ov_ram_addr, bus.o_ram_rd, bus.ov_queue_wdata, bus.ov_queue_wr,
                bus.ov_refcnt, bus.o_refcnt_wr, bus.ov_free_bufid, bus.o_free_wr});
  endfunction

  // Expected response follows straight from the forwarding table contents.
  task automatic applyStimulus(input logic [FLOWID_W-1:0] flow, input logic [BUFID_W-1:0] bufid);
    logic [TSNTAG_W-1:0] tag;
    exp_t e;
    tag = TSNTAG_W'({$urandom(), $urandom()});
    tag[44:31] = flow;
    e.bitmap  = fwd_ram[flow];
    e.is_free = (e.bitmap == '0);
    e.bufid   = bufid;
    e.refcnt  = $countones(e.bitmap);
    sb.push_back(e);
    fifo_q.push_back({tag, bufid});
    bus.i_fifo_empty = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #3;
  endtask

  task automatic waitIdle(input int budget, input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || fifo_q.size() != 0 || in_flight || free_active) && k < budget) begin
      tick();
      k++;
    end
    checkOutput({name, "_timeout"}, 64'(k >= budget), 64'(0));
  endtask

  // Environment: FIFO head valid only the cycle after a pop, RAM data only two cycles after the strobe.
  initial begin
    bit pop_pending;
    int env_rd_cyc;
    int r;
    int free_cnt;
    int ram_cd;
    logic [FLOWID_W-1:0] ram_addr_l;
    pop_pending = 1'b0;
    env_rd_cyc  = -100;
    free_cnt    = 0;
    ram_cd      = 0;
    ram_addr_l  = '0;
    bus.iv_fifo_rdata = '0;
    bus.i_fifo_empty  = 1'b1;
    bus.iv_ram_rdata  = '0;
    bus.i_queue_full  = '0;
    bus.i_free_ack    = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      cyc++;
      bus.iv_fifo_rdata = DESC_W'({$urandom(), $urandom()});
      if (pop_pending && fifo_q.size() > 0) bus.iv_fifo_rdata = fifo_q.pop_front();
      pop_pending = bus.o_fifo_rd;
      if (bus.o_fifo_rd) env_rd_cyc = cyc;
      bus.i_fifo_empty = (fifo_q.size() == 0);

      bus.iv_ram_rdata = PORT_NUM'($urandom());
      if (ram_cd == 1) bus.iv_ram_rdata = fwd_ram[ram_addr_l];
      if (ram_cd > 0) ram_cd--;
      if (bus.o_ram_rd) begin
        ram_cd     = 2;
        ram_addr_l = bus.ov_ram_addr;
      end

      r = cyc - env_rd_cyc;
      if (full_sparse)
        bus.i_queue_full = PORT_NUM'($urandom()) & PORT_NUM'($urandom()) & PORT_NUM'($urandom()) & full_mask;
      else
        bus.i_queue_full = PORT_NUM'($urandom()) & full_mask;
      if (stall_arm && r >= 5 && r <= 8) bus.i_queue_full[7] = 1'b1;

      if (bus.o_free_wr) free_cnt++;
      else free_cnt = 0;
      bus.i_free_ack = bus.o_free_wr && (free_cnt == ack_delay);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a queue write or a free request.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #2;
      if (i_rst_n) begin
        if (bus.o_fifo_rd || bus.o_ram_rd || bus.o_refcnt_wr || bus.ov_queue_wr != '0 || bus.o_free_wr)
          strobe_seen++;
        if (!bus.o_refcnt_wr)
          checkOutput("idle_queue_outputs", 64'({bus.ov_queue_wr, bus.ov_queue_wdata, bus.ov_refcnt}), 64'(0));
        if (!bus.o_free_wr)
          checkOutput("idle_free_bufid", 64'(bus.ov_free_bufid), 64'(0));

        if (!bus.o_free_wr && free_active) begin
          free_active = 1'b0;
          in_flight   = 1'b0;
          checkOutput("free_hold_len", 64'(free_len), 64'(ack_delay));
        end

        if (bus.o_fifo_rd) begin
          checkOutput("rd_while_busy", 64'(in_flight), 64'(0));
          in_flight  = 1'b1;
          mon_rd_cyc = cyc;
          exp_done   = -1;
          rd_cycles.push_back(cyc);
        end

        if (in_flight && exp_done < 0 && (cyc - mon_rd_cyc) >= 5) begin
          if (sb.size() == 0) begin
            checkOutput("sb_underflow", 64'(1), 64'(0));
            in_flight = 1'b0;
          end else if (sb[0].is_free) begin
            exp_done = mon_rd_cyc + 6;
          end else if ((bus.i_queue_full & sb[0].bitmap) == '0) begin
            exp_done = cyc + 1;
          end
        end

        if (bus.o_refcnt_wr || bus.ov_queue_wr != '0) begin
          if (sb.size() == 0 || !in_flight) begin
            checkOutput("unexpected_write", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            checkOutput("write_not_free", 64'(e.is_free), 64'(0));
            checkOutput("queue_wr", 64'(bus.ov_queue_wr), 64'(e.bitmap));
            checkOutput("queue_wdata", 64'(bus.ov_queue_wdata), 64'(e.bufid));
            checkOutput("refcnt", 64'(bus.ov_refcnt), 64'(e.refcnt));
            checkOutput("refcnt_wr", 64'(bus.o_refcnt_wr), 64'(1));
            checkOutput("write_cycle", 64'(cyc), 64'(exp_done));
            last_lat  = cyc - mon_rd_cyc;
            in_flight = 1'b0;
          end
        end

        if (bus.o_free_wr && !free_active) begin
          if (sb.size() == 0 || !in_flight) begin
            checkOutput("unexpected_free", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            checkOutput("free_expected", 64'(e.is_free), 64'(1));
            checkOutput("free_cycle", 64'(cyc), 64'(exp_done));
            free_bufid_exp = e.bufid;
            last_lat       = cyc - mon_rd_cyc;
          end
          free_active = 1'b1;
          free_len    = 0;
        end
        if (bus.o_free_wr) begin
          free_len++;
          checkOutput("free_bufid", 64'(bus.ov_free_bufid), 64'(free_bufid_exp));
        end
      end
    end
  end

  initial begin
    int push_cyc;
    int n0;
    int k;
    for (int i = 0; i < NUM_FLOWS; i++) fwd_ram[i] = '0;

    #2;
    checkOutput("reset_outputs", all_outputs(), 64'(0));
    repeat (3) tick();
    i_rst_n = 1'b1;

    $display("[TB] empty FIFO, no strobes expected");
    strobe_seen = 0;
    repeat (30) tick();
    checkOutput("empty_no_strobe", 64'(strobe_seen), 64'(0));

    $display("[TB] single descriptor, flow 5 -> ports 0 and 2");
    fwd_ram[5] = 8'b0000_0101;
    rd_cycles.delete();
    push_cyc = cyc;
    applyStimulus(14'd5, 9'd17);
    waitIdle(100, "single");
    checkOutput("single_rd_count", 64'(rd_cycles.size()), 64'(1));
    if (rd_cycles.size() > 0) checkOutput("single_rd_cycle", 64'(rd_cycles[0]), 64'(push_cyc + 1));
    checkOutput("single_latency", 64'(last_lat), 64'(6));

    $display("[TB] empty bitmap returns buffer 33");
    fwd_ram[9] = '0;
    ack_delay = 3;
    applyStimulus(14'd9, 9'd33);
    waitIdle(100, "free");
    checkOutput("free_latency", 64'(last_lat), 64'(6));

    $display("[TB] bitmap 0x81 with port 7 full, port 3 toggling");
    fwd_ram[77] = 8'h81;
    stall_arm = 1'b1;
    full_mask = 8'h08;
    applyStimulus(14'd77, 9'd200);
    waitIdle(100, "stall");
    checkOutput("stall_latency", 64'(last_lat), 64'(10));
    stall_arm = 1'b0;
    full_mask = '0;

    $display("[TB] three back-to-back descriptors");
    fwd_ram[30] = 8'h01;
    fwd_ram[31] = 8'hFF;
    fwd_ram[32] = 8'h10;
    rd_cycles.delete();
    applyStimulus(14'd30, 9'd60);
    applyStimulus(14'd31, 9'd61);
    applyStimulus(14'd32, 9'd62);
    waitIdle(200, "b2b");
    checkOutput("b2b_rd_count", 64'(rd_cycles.size()), 64'(3));
    if (rd_cycles.size() == 3) begin
      checkOutput("b2b_spacing_1", 64'(rd_cycles[1] - rd_cycles[0]), 64'(7));
      checkOutput("b2b_spacing_2", 64'(rd_cycles[2] - rd_cycles[1]), 64'(7));
    end

    $display("[TB] reset during WAIT1");
    fwd_ram[20] = 8'h3C;
    fwd_ram[21] = 8'h42;
    n0 = rd_cycles.size();
    applyStimulus(14'd20, 9'd50);
    k = 0;
    while (rd_cycles.size() == n0 && k < 20) begin
      tick();
      k++;
    end
    checkOutput("reset_wait_rd", 64'(k >= 20), 64'(0));
    if (rd_cycles.size() > n0) begin
      while (cyc < rd_cycles[$] + 2) tick();
      checkOutput("ram_rd_before_reset", 64'(bus.o_ram_rd), 64'(1));
    end
    i_rst_n = 1'b0;
    #1;
    checkOutput("outputs_in_reset", all_outputs(), 64'(0));
    sb.delete();
    in_flight   = 1'b0;
    free_active = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    applyStimulus(14'd21, 9'd51);
    waitIdle(100, "after_reset");
    checkOutput("after_reset_latency", 64'(last_lat), 64'(6));

    $display("[TB] randomized descriptors with sparse full ports");
    full_mask   = '1;
    full_sparse = 1'b1;
    ack_delay   = 1 + int'($urandom_range(3));
    for (int i = 0; i < 40; i++) begin
      logic [FLOWID_W-1:0] flow;
      flow = FLOWID_W'(1000 + i * 37);
      fwd_ram[flow] = ($urandom_range(3) == 0) ? '0 : PORT_NUM'($urandom());
      k = 0;
      while (fifo_q.size() >= 2 && k < 100) begin
        tick();
        k++;
      end
      repeat ($urandom_range(3)) tick();
      applyStimulus(flow, BUFID_W'($urandom()));
    end
    waitIdle(3000, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
